// File: rtl/wb_regfile.sv
// Writeback stage: selects the WB value, commits it to the integer register file,
// serves two combinational read ports with write-first bypass, and tracks retirement.
module wb_regfile #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREG  = 32,
  parameter int unsigned CNT_W = 64
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wb_valid,
  input  logic             i_wb_RegWEn,
  input  logic [1:0]       i_wb_sel,
  input  logic [4:0]       i_wb_rd,
  input  logic [XLEN-1:0]  i_wb_ALU_out,
  input  logic [XLEN-1:0]  i_wb_WBData,
  input  logic [XLEN-1:0]  i_wb_pc,
  input  logic [XLEN-1:0]  i_wb_imm,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  output logic [XLEN-1:0]  o_id_rs1_data,
  output logic [XLEN-1:0]  o_id_rs2_data,
  output logic [XLEN-1:0]  o_wb_wr_data,
  output logic [CNT_W-1:0] o_retired,
  output logic [4:0]       o_last_rd,
  output logic [XLEN-1:0]  o_last_data
);

  logic [XLEN-1:0]  r_regs [NREG];
  logic [CNT_W-1:0] r_retired;
  logic [4:0]       r_last_rd;
  logic [XLEN-1:0]  r_last_data;

  logic             w_we;
  logic [XLEN-1:0]  w_wr_data;

  // Reset suppresses both the commit and the bypass path.
  assign w_we = i_wb_valid & i_wb_RegWEn & (i_wb_rd != 5'd0) & ~i_rst;

  always_comb begin
    w_wr_data = '0;
    unique case (i_wb_sel)
      2'b00: w_wr_data = i_wb_ALU_out;
      2'b01: w_wr_data = i_wb_WBData;
      2'b10: w_wr_data = i_wb_pc + XLEN'(4);
      2'b11: w_wr_data = i_wb_imm;
      default: w_wr_data = '0;
    endcase
  end

  always_comb begin
    o_id_rs1_data = '0;
    if (i_id_rs1 != 5'd0) begin
      if (w_we && (i_id_rs1 == i_wb_rd)) o_id_rs1_data = w_wr_data;
      else                               o_id_rs1_data = r_regs[i_id_rs1];
    end
  end

  always_comb begin
    o_id_rs2_data = '0;
    if (i_id_rs2 != 5'd0) begin
      if (w_we && (i_id_rs2 == i_wb_rd)) o_id_rs2_data = w_wr_data;
      else                               o_id_rs2_data = r_regs[i_id_rs2];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < NREG; i++) r_regs[i] <= '0;
      r_retired   <= '0;
      r_last_rd   <= '0;
      r_last_data <= '0;
    end else begin
      if (w_we) begin
        r_regs[i_wb_rd] <= w_wr_data;
        r_last_rd       <= i_wb_rd;
        r_last_data     <= w_wr_data;
      end
      if (i_wb_valid) r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign o_wb_wr_data = w_wr_data;
  assign o_retired    = r_retired;
  assign o_last_rd    = r_last_rd;
  assign o_last_data  = r_last_data;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: a full-width instance plus a 4-bit-counter instance
// sharing the same stimulus to exercise counter wraparound.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic        wb_RegWEn;
  logic [1:0]  wb_sel;
  logic [4:0]  wb_rd;
  logic [31:0] wb_ALU_out;
  logic [31:0] wb_WBData;
  logic [31:0] wb_pc;
  logic [31:0] wb_imm;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;

  logic [31:0] rs1_data, rs2_data, wr_data, last_data;
  logic [63:0] retired;
  logic [4:0]  last_rd;

  logic [31:0] s_rs1_data, s_rs2_data, s_wr_data, s_last_data;
  logic [3:0]  s_retired;
  logic [4:0]  s_last_rd;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [63:0] exp_ret = '0;
  logic [3:0]  s_start;

  always #5 clk = ~clk;

  wb_regfile u_dut (
    .i_clk(clk), .i_rst(rst), .i_wb_valid(wb_valid), .i_wb_RegWEn(wb_RegWEn),
    .i_wb_sel(wb_sel), .i_wb_rd(wb_rd), .i_wb_ALU_out(wb_ALU_out),
    .i_wb_WBData(wb_WBData), .i_wb_pc(wb_pc), .i_wb_imm(wb_imm),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .o_id_rs1_data(rs1_data),
    .o_id_rs2_data(rs2_data), .o_wb_wr_data(wr_data), .o_retired(retired),
    .o_last_rd(last_rd), .o_last_data(last_data)
  );

  wb_regfile #(.CNT_W(4)) u_dut_small (
    .i_clk(clk), .i_rst(rst), .i_wb_valid(wb_valid), .i_wb_RegWEn(wb_RegWEn),
    .i_wb_sel(wb_sel), .i_wb_rd(wb_rd), .i_wb_ALU_out(wb_ALU_out),
    .i_wb_WBData(wb_WBData), .i_wb_pc(wb_pc), .i_wb_imm(wb_imm),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .o_id_rs1_data(s_rs1_data),
    .o_id_rs2_data(s_rs2_data), .o_wb_wr_data(s_wr_data), .o_retired(s_retired),
    .o_last_rd(s_last_rd), .o_last_data(s_last_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [1:0] sel,
                       input logic [4:0] rd, input logic [31:0] d);
    wb_valid  = v;
    wb_RegWEn = we;
    wb_sel    = sel;
    wb_rd     = rd;
    wb_ALU_out = d;
    wb_WBData  = d;
    wb_pc      = d;
    wb_imm     = d;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 2'b00, 5'd0, 32'h0);
    id_rs1 = 5'd0;
    id_rs2 = 5'd0;
    tick();
    tick();

    // Reset state: every index reads zero on both ports
    for (int i = 0; i < 32; i++) begin
      id_rs1 = 5'(i);
      id_rs2 = 5'(31 - i);
      #1;
      chk("rst_rs1", rs1_data, 0);
      chk("rst_rs2", rs2_data, 0);
    end
    chk("rst_retired", retired, 0);
    chk("rst_small_retired", s_retired, 0);
    chk("rst_last_rd", last_rd, 0);
    chk("rst_last_data", last_data, 0);

    // Bypass disabled while reset is held
    drive(1'b1, 1'b1, 2'b00, 5'd3, 32'h0000_0033);
    id_rs1 = 5'd3;
    #1;
    chk("rst_no_bypass", rs1_data, 0);
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 5'd0, 32'h0);
    #1;
    chk("rst_write_dropped", rs1_data, 0);
    chk("rst_count_dropped", retired, 0);

    // ALU write to x5 with same-cycle bypass
    drive(1'b1, 1'b1, 2'b00, 5'd5, 32'hDEAD_BEEF);
    id_rs1 = 5'd5;
    id_rs2 = 5'd0;
    #1;
    chk("alu_wr_data", wr_data, 32'hDEAD_BEEF);
    chk("alu_bypass", rs1_data, 32'hDEAD_BEEF);
    chk("alu_rs2_x0", rs2_data, 0);
    tick();
    exp_ret++;
    drive(1'b0, 1'b0, 2'b00, 5'd0, 32'h0);
    #1;
    chk("alu_stored", rs1_data, 32'hDEAD_BEEF);
    chk("alu_last_rd", last_rd, 5);
    chk("alu_last_data", last_data, 32'hDEAD_BEEF);
    chk("alu_retired", retired, exp_ret);

    // Write to x0 via imm: discarded, but still retires
    drive(1'b1, 1'b1, 2'b11, 5'd0, 32'h1234_5000);
    id_rs1 = 5'd0;
    #1;
    chk("x0_wr_data", wr_data, 32'h1234_5000);
    chk("x0_bypass", rs1_data, 0);
    tick();
    exp_ret++;
    drive(1'b0, 1'b0, 2'b00, 5'd0, 32'h0);
    #1;
    chk("x0_stored", rs1_data, 0);
    chk("x0_last_rd", last_rd, 5);
    chk("x0_last_data", last_data, 32'hDEAD_BEEF);
    chk("x0_retired", retired, exp_ret);

    // Bubble with RegWEn set: no bypass, no write
    drive(1'b0, 1'b1, 2'b00, 5'd9, 32'h0000_0099);
    id_rs1 = 5'd9;
    #1;
    chk("bubble_no_bypass", rs1_data, 0);
    tick();
    #1;
    chk("bubble_no_write", rs1_data, 0);
    chk("bubble_retired", retired, exp_ret);

    // x1 = 0x55, then pc+4 wraps to zero and overwrites it
    drive(1'b1, 1'b1, 2'b00, 5'd1, 32'h0000_0055);
    tick();
    exp_ret++;
    drive(1'b1, 1'b1, 2'b10, 5'd1, 32'hFFFF_FFFC);
    id_rs1 = 5'd1;
    #1;
    chk("pc4_before", u_dut.r_regs[1], 32'h55);
    chk("pc4_wr_data", wr_data, 0);
    chk("pc4_bypass", rs1_data, 0);
    tick();
    exp_ret++;

    // Load into x31, both ports bypass
    drive(1'b1, 1'b1, 2'b01, 5'd31, 32'hA5A5_A5A5);
    id_rs1 = 5'd31;
    id_rs2 = 5'd31;
    #1;
    chk("ld_wr_data", wr_data, 32'hA5A5_A5A5);
    chk("ld_rs1_bypass", rs1_data, 32'hA5A5_A5A5);
    chk("ld_rs2_bypass", rs2_data, 32'hA5A5_A5A5);
    tick();
    exp_ret++;
    drive(1'b0, 1'b0, 2'b00, 5'd0, 32'h0);
    id_rs1 = 5'd1;
    #1;
    chk("pc4_stored", rs1_data, 0);
    chk("ld_stored", rs2_data, 32'hA5A5_A5A5);
    chk("ld_last_rd", last_rd, 31);
    chk("ld_last_data", last_data, 32'hA5A5_A5A5);
    chk("ld_retired", retired, exp_ret);

    // Write presented together with reset is lost
    rst = 1'b1;
    drive(1'b1, 1'b1, 2'b00, 5'd7, 32'h0000_0011);
    id_rs1 = 5'd7;
    id_rs2 = 5'd5;
    #1;
    chk("midrst_no_bypass", rs1_data, 0);
    tick();
    exp_ret = '0;
    rst = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 5'd0, 32'h0);
    #1;
    chk("midrst_x7", rs1_data, 0);
    chk("midrst_x5", rs2_data, 0);
    chk("midrst_retired", retired, exp_ret);
    chk("midrst_last_rd", last_rd, 0);

    // First write after reset commits
    drive(1'b1, 1'b1, 2'b00, 5'd7, 32'h0000_0011);
    tick();
    exp_ret++;
    drive(1'b0, 1'b0, 2'b00, 5'd0, 32'h0);
    #1;
    chk("postrst_x7", rs1_data, 32'h11);
    chk("postrst_retired", retired, exp_ret);

    // Ten stores: retire without touching registers
    drive(1'b1, 1'b0, 2'b00, 5'd7, 32'h0000_00FF);
    #1;
    chk("store_no_bypass", rs1_data, 32'h11);
    for (int i = 0; i < 10; i++) begin
      tick();
      exp_ret++;
    end
    drive(1'b0, 1'b0, 2'b00, 5'd0, 32'h0);
    #1;
    chk("store_x7", rs1_data, 32'h11);
    chk("store_last_rd", last_rd, 7);
    chk("store_last_data", last_data, 32'h11);
    chk("store_retired", retired, exp_ret);
    chk("store_small_retired", s_retired, exp_ret[3:0]);

    // Bring the 4-bit counter to 13, then 16 valid cycles wrap it back to 13
    drive(1'b1, 1'b0, 2'b00, 5'd7, 32'h0);
    tick();
    tick();
    exp_ret = exp_ret + 2;
    chk("wrap_pre_small", s_retired, 4'd13);
    s_start = exp_ret[3:0];
    for (int i = 0; i < 16; i++) begin
      tick();
      exp_ret++;
      if (i == 2) chk("wrap_cross_small", s_retired, 4'd0);
    end
    drive(1'b0, 1'b0, 2'b00, 5'd0, 32'h0);
    #1;
    chk("wrap_small_retired", s_retired, s_start);
    chk("wrap_big_retired", retired, exp_ret);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback-side consumer of the MEM/WB pipeline register outputs.
- Selects the writeback value and commits it to the 32x32 integer register file.
- Serves the two decode-stage read ports, with same-cycle write-to-read bypass.
- Keeps a retired-instruction counter and a last-write debug snapshot.

Parameters:
- XLEN, 32, data width of registers and writeback paths
- NREG, 32, number of architectural registers; x0 is hardwired to zero
- CNT_W, 64, width of the retired-instruction counter

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- wb_valid  in  1  an instruction is present in WB this cycle
- wb_RegWEn  in  1  the instruction writes rd
- wb_sel  in  2  writeback source: 00 ALU_out, 01 WBData (load), 10 pc+4, 11 imm
- wb_rd  in  5  destination register index
- wb_ALU_out  in  XLEN  ALU result
- wb_WBData  in  XLEN  load data from memory stage
- wb_pc  in  XLEN  instruction PC
- wb_imm  in  XLEN  immediate (LUI)
- id_rs1  in  5  read port A index
- id_rs2  in  5  read port B index
- id_rs1_data  out  XLEN  read port A data (combinational)
- id_rs2_data  out  XLEN  read port B data (combinational)
- wb_wr_data  out  XLEN  selected writeback value this cycle (combinational, for forwarding)
- retired  out  CNT_W  count of retired instructions
- last_rd  out  5  index of last committed write
- last_data  out  XLEN  value of last committed write

Behaviour:
- Write enable: we = wb_valid & wb_RegWEn & (wb_rd != 0) & !rst.
- Writeback mux: wb_wr_data is a pure function of wb_sel and the data inputs, independent of wb_valid.
  - pc+4 is computed modulo 2^XLEN, so 0xFFFFFFFC + 4 = 0.
- Commit: on posedge clk with we=1, regs[wb_rd] <= wb_wr_data, last_rd <= wb_rd, last_data <= wb_wr_data.
- Stores with wb_RegWEn=0 and writes to x0 change no register and do not update last_rd/last_data.
- Reads are combinational:
  - Index 0 always returns 0.
  - If we=1 and id_rsN == wb_rd, the output is wb_wr_data (write-first bypass, zero-cycle latency).
  - Otherwise the output is regs[id_rsN].
- Both read ports are independent; rs1 == rs2 == wb_rd bypasses both.
- Retired counter: increments by 1 on each posedge where wb_valid=1 and rst=0, regardless of RegWEn.
  - Wraps from all-ones to 0 without saturation.
- Reset: at a posedge with rst=1:
  - All regs, retired, last_rd and last_data go to 0.
  - Any concurrent write or count is dropped.
  - While rst=1, bypass is disabled, so reads return stored (post-reset zero) values.
- Reset mid-stream: a write presented in the same cycle rst is asserted is lost.
  - The first write after rst deasserts commits normally.
- No stall input: WB never stalls. Upstream holds wb_valid=0 for bubbles.
- Latency: a write is visible through the bypass in cycle N and from storage from cycle N+1.

Test Plan:
- Reset then read all indices -> every id_rs1_data/id_rs2_data = 0; retired = 0; last_rd = 0, last_data = 0.
- wb_valid=1, RegWEn=1, rd=5, sel=00, ALU_out=0xDEADBEEF, id_rs1=5 -> id_rs1_data = 0xDEADBEEF in the same cycle (bypass).
  - Next cycle with wb_valid=0 -> still 0xDEADBEEF; last_rd = 5; retired = 1.
- Write rd=0 with sel=11, imm=0x12345000 -> id_rs1=0 reads 0 in that cycle and after; last_rd/last_data unchanged; retired increments.
- sel=10, pc=0xFFFFFFFC, rd=1 -> wb_wr_data = 0x00000000, x1 = 0.
  - sel=01, WBData=0xA5A5A5A5, rd=31, with id_rs1 = id_rs2 = 31 -> both ports read 0xA5A5A5A5.
- Write x7=0x11 in cycle N with rst=1 in cycle N -> x7 reads 0 afterwards, retired = 0.
  - Repeat with rst=0 -> x7 = 0x11.
- 10 cycles wb_valid=1, RegWEn=0 (stores) -> retired = 10, no register changed.
  - With retired preset near wrap (CNT_W reduced to 4 in the bench), 16 valid cycles -> retired returns to its start value.
